ps2_key_sequencer: RTL and testbench

Sequences keyboard key events into the byte stream consumed by `ps2_master`. It queues events from the ADB decode side and expands each one into its PS/2 Set 2 byte sequence: optional `E0` prefix, optional `F0` break prefix, then the scancode. It drives the `ps2_master` valid/ready byte interface one byte at a time. It sits between the ADB key decoder and `ps2_master`.

---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_key_sequencer_fifo.sv | 47 ++++
 rtl/ps2_key_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 sequencing types: prefix bytes, key event record, sequencer states
// and the byte/state helpers used to expand an event into its Set 2 byte sequence.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_key_ev_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFIX_E0 = 3'd1,
        ST_PREFIX_F0 = 3'd2,
        ST_CODE      = 3'd3,
        ST_GAP       = 3'd4
    } ps2_seq_state_t;

    function automatic ps2_seq_state_t seq_first(input ps2_key_ev_t ev);
        if (ev.ext)      return ST_PREFIX_E0;
        else if (ev.brk) return ST_PREFIX_F0;
        else             return ST_CODE;
    endfunction

    // State that follows a completed transfer in st (before any gap is inserted).
    function automatic ps2_seq_state_t seq_after(input ps2_seq_state_t st, input ps2_key_ev_t ev);
        case (st)
            ST_PREFIX_E0: return ev.brk ? ST_PREFIX_F0 : ST_CODE;
            ST_PREFIX_F0: return ST_CODE;
            default:      return ST_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] seq_byte(input ps2_seq_state_t st, input ps2_key_ev_t ev);
        case (st)
            ST_PREFIX_E0: return PS2_PREFIX_EXT;
            ST_PREFIX_F0: return PS2_PREFIX_BRK;
            default:      return ev.code;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_sequencer_fifo.sv
// ps2_event_fifo: synchronous FIFO with wrap-bit pointers; read data is the
// combinational head entry, valid whenever empty is low.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Queues key events and streams their PS/2 Set 2 bytes (E0 / F0 / code) to ps2_master.
// Optional inter-byte idle gap compiled in with `define PS2_SEQ_GAP_EN.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ev_code,
    input  logic       ev_ext,
    input  logic       ev_brk,
    input  logic       ev_valid,
    output logic       ev_ready,
    output logic [7:0] tdata,
    output logic       tvalid,
    input  logic       tready,
    output logic       busy
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int EV_W  = $bits(ps2_key_ev_t);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be at least 1");
    end

    ps2_key_ev_t    head;
    ps2_key_ev_t    push_ev;
    ps2_key_ev_t    hold;
    ps2_key_ev_t    hold_d;
    ps2_seq_state_t state;
    ps2_seq_state_t state_d;
    ps2_seq_state_t nxt;
    logic [7:0]     tdata_d;
    logic           tvalid_d;
    logic           busy_d;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_d;

`ifdef PS2_SEQ_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_d;
    ps2_seq_state_t   pend;
    ps2_seq_state_t   pend_d;
`endif

    assign push_ev  = '{ext: ev_ext, brk: ev_brk, code: ev_code};
    assign push     = ev_valid && !full;
    assign ev_ready = !full;

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_ev),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_comb begin
        state_d  = state;
        hold_d   = hold;
        tdata_d  = tdata;
        tvalid_d = tvalid;
        pop      = 1'b0;
        nxt      = ST_IDLE;
`ifdef PS2_SEQ_GAP_EN
        gap_d    = gap_cnt;
        pend_d   = pend;
`endif
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    hold_d   = head;
                    state_d  = seq_first(head);
                    tdata_d  = seq_byte(seq_first(head), head);
                    tvalid_d = 1'b1;
                end
            end
            ST_PREFIX_E0, ST_PREFIX_F0, ST_CODE: begin
                if (tvalid && tready) begin
                    nxt = seq_after(state, hold);
`ifdef PS2_SEQ_GAP_EN
                    state_d  = ST_GAP;
                    pend_d   = nxt;
                    tvalid_d = 1'b0;
                    gap_d    = GAP_W'(GAP_CYCLES - 1);
`else
                    if (nxt != ST_IDLE) begin
                        state_d = nxt;
                        tdata_d = seq_byte(nxt, hold);
                    end else if (!empty) begin
                        // Chain straight into the next queued event with no idle cycle.
                        pop     = 1'b1;
                        hold_d  = head;
                        state_d = seq_first(head);
                        tdata_d = seq_byte(seq_first(head), head);
                    end else begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                    end
`endif
                end
            end
`ifdef PS2_SEQ_GAP_EN
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_d = pend;
                    if (pend != ST_IDLE) begin
                        tdata_d  = seq_byte(pend, hold);
                        tvalid_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_cnt - GAP_W'(1);
                end
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    assign level_d = level + LVL_W'(push) - LVL_W'(pop);
    assign busy_d  = (state_d != ST_IDLE) || (level_d != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            tdata  <= 8'h00;
            tvalid <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            tdata  <= tdata_d;
            tvalid <= tvalid_d;
            busy   <= busy_d;
        end
    end

`ifdef PS2_SEQ_GAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            pend    <= ST_IDLE;
        end else begin
            gap_cnt <= gap_d;
            pend    <= pend_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        hold <= hold_d;
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: events expand to expected bytes in a queue,
// a negedge monitor checks every handshake. Gap checks active with PS2_SEQ_GAP_EN.
module tb_ps2_key_sequencer;
    localparam int GAP = 16;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ev_code = 8'h00;
    logic       ev_ext = 1'b0;
    logic       ev_brk = 1'b0;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready = 1'b0;
    logic       busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    bit   rand_on = 1'b0;

    ps2_key_sequencer #(.DEPTH(4), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_brk   (ev_brk),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .tdata    (tdata),
        .tvalid   (tvalid),
        .tready   (tready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference expansion of one key event into its Set 2 byte stream.
    task automatic model_push(input logic [7:0] c, input logic e, input logic b);
        exp_t x;
        if (e) begin x.b = 8'hE0; x.last = 1'b0; exp_q.push_back(x); end
        if (b) begin x.b = 8'hF0; x.last = 1'b0; exp_q.push_back(x); end
        x.b = c; x.last = 1'b1; exp_q.push_back(x);
    endtask

    // Called at posedge+1; returns 1ns after the acceptance edge.
    task automatic send_event(input logic [7:0] c, input logic e, input logic b);
        int k;
        k = 0;
        ev_code = c; ev_ext = e; ev_brk = b; ev_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (ev_ready) break;
            k++;
            if (k > 1000) begin
                check("ev_accept_timeout", 32'd1, 32'd0);
                @(posedge clk); #1 ev_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_push(c, e, b);
        #1 ev_valid = 1'b0;
    endtask

    task automatic wait_tvalid();
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (tvalid) break;
            k++;
            if (k > 1000) begin check("tvalid_timeout", 32'd1, 32'd0); return; end
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            k++;
            if (k > 3000) break;
        end
        check("drained_queue", exp_q.size(), 0);
        check("drained_busy", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    // Monitor: every handshake must match the next expected byte.
    bit gap_armed = 1'b0;
    bit gap_after_last = 1'b0;
    int gap_len = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            gap_armed = 1'b0;
        end else begin
`ifdef PS2_SEQ_GAP_EN
            if (gap_armed) begin
                if (!tvalid) gap_len++;
                else begin
                    gap_armed = 1'b0;
                    if (gap_after_last) check("gap_min_len", gap_len >= GAP, 1'b1);
                    else                check("gap_len", gap_len, GAP);
                end
            end
`endif
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", tdata, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", tdata, e.b);
                    gap_armed = 1'b1;
                    gap_after_last = e.last;
                    gap_len = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_on) tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [3];
        int d;
        seq = '{8'hE0, 8'hF0, 8'h75};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ev_ready", ev_ready, 1'b1);
        rst_n = 1'b1;
        tready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Make 1C: latency and busy release
        send_event(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_tvalid_N", tvalid, 1'b0);
        check("lat_busy_N", busy, 1'b1);
        @(negedge clk);
        check("lat_tvalid_N1", tvalid, 1'b1);
        check("lat_tdata_N1", tdata, 8'h1C);
        @(posedge clk); #1;
`ifdef PS2_SEQ_GAP_EN
        check("gap_busy_held", busy, 1'b1);
        repeat (GAP) begin @(posedge clk); #1; end
`endif
        check("post_busy", busy, 1'b0);
        check("post_tvalid", tvalid, 1'b0);
        wait_idle();

        // Extended break 75 (5A ext in gap build)
`ifdef PS2_SEQ_GAP_EN
        send_event(8'h5A, 1'b1, 1'b0);
        wait_idle();
        send_event(8'h75, 1'b1, 1'b1);
        wait_idle();
`else
        send_event(8'h75, 1'b1, 1'b1);
        wait_tvalid();
        for (int i = 0; i < 3; i++) begin
            check("b2b_tvalid", tvalid, 1'b1);
            check("b2b_tdata", tdata, seq[i]);
            @(negedge clk);
        end
        check("b2b_done_tvalid", tvalid, 1'b0);
        @(posedge clk); #1;
        wait_idle();
`endif

        // Break 1C stalled by tready
        tready = 1'b0;
        send_event(8'h1C, 1'b0, 1'b1);
        wait_tvalid();
        for (int i = 0; i < 10; i++) begin
            check("stall_tvalid", tvalid, 1'b1);
            check("stall_tdata", tdata, 8'hF0);
            @(negedge clk);
        end
        @(posedge clk); #1 tready = 1'b1;
        wait_idle();

        // FIFO full: one event in the holding register, four queued
        tready = 1'b0;
        send_event(8'h11, 1'b0, 1'b0);
        wait_tvalid();
        @(posedge clk); #1;
        send_event(8'h22, 1'b1, 1'b0);
        send_event(8'h33, 1'b0, 1'b1);
        send_event(8'h44, 1'b0, 1'b0);
        send_event(8'h55, 1'b1, 1'b1);
        check("full_ev_ready", ev_ready, 1'b0);
        ev_code = 8'h66; ev_ext = 1'b0; ev_brk = 1'b0; ev_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_hold_ready", ev_ready, 1'b0);
        end
        @(posedge clk); #1 tready = 1'b1;
        send_event(8'h66, 1'b0, 1'b0);
        wait_idle();

        // Asynchronous reset mid-sequence
        tready = 1'b0;
        send_event(8'h2B, 1'b0, 1'b1);
        send_event(8'h4D, 1'b1, 1'b0);
        wait_tvalid();
        check("pre_rst_tdata", tdata, 8'hF0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tvalid", tvalid, 1'b0);
        check("arst_ev_ready", ev_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        tready = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_tvalid", tvalid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        send_event(8'h29, 1'b0, 1'b0);
        wait_idle();

        // Randomized events with random backpressure
        rand_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(0, 3);
            repeat (d) begin @(posedge clk); #1; end
            send_event(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_on = 1'b0;
        @(posedge clk); #2 tready = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
